// File: rtl/arb_requester.sv
// Requester-side client of a two-input request/grant arbiter: buffers words in a
// small FIFO, requests the bus while data is pending, and drains bounded bursts.
module arb_requester #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_gnt,
  output logic              o_req,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_full,
  output logic              o_drop,
  output logic              o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [BW-1:0]     beat_cnt, beat_nxt;
  logic [WW-1:0]     wait_cnt, wait_nxt;
  logic              push, pop, drop, tmo;
  logic              vld_p1, drop_p1, tmo_p1;
  logic [DATA_W-1:0] data_p1;

  always_comb begin
    push      = i_wr_en && (count != CW'(DEPTH));
    drop      = i_wr_en && (count == CW'(DEPTH));
    pop       = 1'b0;
    tmo       = 1'b0;
    state_nxt = state;
    beat_nxt  = beat_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = REQ;
      end
      REQ, XFER: begin
        if (i_gnt && (count != '0)) begin
          pop       = 1'b1;
          beat_nxt  = beat_cnt + BW'(1);
          wait_nxt  = '0;
          state_nxt = XFER;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
          if (wait_nxt == WW'(TIMEOUT)) begin
            state_nxt = RELEASE;
            tmo       = 1'b1;
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
        wait_nxt  = '0;
      end
    endcase
    count_nxt = count + CW'(push) - CW'(pop);
    // The beat that fills the burst quota or empties the FIFO also ends the request.
    if (pop && ((beat_nxt == BW'(MAX_BURST)) || (count_nxt == '0)))
      state_nxt = RELEASE;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // Stage p1: registered bus beat and status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      drop_p1  <= 1'b0;
      tmo_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      beat_cnt <= beat_nxt;
      wait_cnt <= wait_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      vld_p1   <= pop;
      if (pop) data_p1 <= mem[rd_ptr];
      drop_p1  <= drop;
      tmo_p1   <= tmo;
    end
  end

  assign o_req       = (state == REQ) || (state == XFER);
  assign o_bus_valid = vld_p1;
  assign o_bus_data  = data_p1;
  assign o_full      = (count == CW'(DEPTH));
  assign o_drop      = drop_p1;
  assign o_timeout   = tmo_p1;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester (DEPTH=4, MAX_BURST=4, TIMEOUT=15): a vector
// table per clock edge plus hand-written pause, reset and timeout sequences.
module tb_arb_requester;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       gnt;
  logic       req;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       full;
  logic       drop;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  arb_requester #(.DATA_W(8), .DEPTH(4), .MAX_BURST(4), .TIMEOUT(15)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_gnt      (gnt),
    .o_req      (req),
    .o_bus_valid(bus_valid),
    .o_bus_data (bus_data),
    .o_full     (full),
    .o_drop     (drop),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       gnt;
    logic       req;
    logic       vld;
    logic [7:0] bd;
    logic       full;
    logic       drop;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic g,
                              logic q, logic vl, logic [7:0] bd,
                              logic f, logic dr, logic t);
    vec_t x;
    x.rst = r; x.wr = w; x.wd = d; x.gnt = g;
    x.req = q; x.vld = vl; x.bd = bd; x.full = f; x.drop = dr; x.tmo = t;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic g);
    rst = r; wr_en = w; wr_data = d; gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic q, input logic vl,
                            input logic [7:0] bd, input logic f, input logic dr,
                            input logic t, input bit cd);
    chk({tag, ".req"},     req,       q);
    chk({tag, ".valid"},   bus_valid, vl);
    if (cd) chk({tag, ".data"}, bus_data, bd);
    chk({tag, ".full"},    full,      f);
    chk({tag, ".drop"},    drop,      dr);
    chk({tag, ".timeout"}, timeout,   t);
  endtask

  int req_hi;
  int tmo_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; gnt = 1'b0;

    // reset, then 4 pushes with grant following request by one cycle
    vecs.push_back(mk(1,0,8'h00,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'h11,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'h22,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'h33,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'h44,1, 1,1,8'h11,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h22,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h33,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,1,8'h44,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0,0,0));
    // fill to full with no grant, overflow drop, drop while popping
    vecs.push_back(mk(0,1,8'hA1,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hA2,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hA3,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hA4,0, 1,0,8'h00,1,0,0));
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,8'h00,1,1,0));
    vecs.push_back(mk(0,0,8'h00,0, 1,0,8'h00,1,0,0));
    vecs.push_back(mk(0,1,8'hA6,1, 1,1,8'hA1,0,1,0));
    vecs.push_back(mk(0,0,8'h00,1, 1,1,8'hA2,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 1,1,8'hA3,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,1,8'hA4,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0,0,0));
    // 6 words: burst of 4, release, re-request, burst of 2
    vecs.push_back(mk(0,1,8'hD1,0, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hD2,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hD3,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,8'hD4,1, 1,1,8'hD1,0,0,0));
    vecs.push_back(mk(0,1,8'hD5,1, 1,1,8'hD2,0,0,0));
    vecs.push_back(mk(0,1,8'hD6,1, 1,1,8'hD3,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,1,8'hD4,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 1,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 1,1,8'hD5,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,1,8'hD6,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].gnt);
      expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].vld, vecs[i].bd,
                 vecs[i].full, vecs[i].drop, vecs[i].tmo, vecs[i].vld || vecs[i].rst);
    end

    // grant pause of 3 cycles after beat 2 of 4
    step(0,1,8'hB1,0); expect_out("pause0", 0,0,8'h00,0,0,0,0);
    step(0,1,8'hB2,0); expect_out("pause1", 1,0,8'h00,0,0,0,0);
    step(0,1,8'hB3,0); expect_out("pause2", 1,0,8'h00,0,0,0,0);
    step(0,1,8'hB4,1); expect_out("pause3", 1,1,8'hB1,0,0,0,1);
    step(0,0,8'h00,1); expect_out("pause4", 1,1,8'hB2,0,0,0,1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,8'h00,0); expect_out($sformatf("pause_gap%0d", i), 1,0,8'h00,0,0,0,0);
    end
    step(0,0,8'h00,1); expect_out("pause8", 1,1,8'hB3,0,0,0,1);
    step(0,0,8'h00,1); expect_out("pause9", 0,1,8'hB4,0,0,0,1);
    step(0,0,8'h00,0); expect_out("pause10", 0,0,8'h00,0,0,0,0);
    step(0,0,8'h00,0); expect_out("pause11", 0,0,8'h00,0,0,0,0);

    // reset after beat 2 of 4 discards the rest
    step(0,1,8'hC1,0); expect_out("rst0", 0,0,8'h00,0,0,0,0);
    step(0,1,8'hC2,0); expect_out("rst1", 1,0,8'h00,0,0,0,0);
    step(0,1,8'hC3,0); expect_out("rst2", 1,0,8'h00,0,0,0,0);
    step(0,1,8'hC4,1); expect_out("rst3", 1,1,8'hC1,0,0,0,1);
    step(0,0,8'h00,1); expect_out("rst4", 1,1,8'hC2,0,0,0,1);
    step(1,0,8'h00,1); expect_out("rst5", 0,0,8'h00,0,0,0,1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,8'h00,1); expect_out($sformatf("rst_idle%0d", i), 0,0,8'h00,0,0,0,0);
    end
    step(0,1,8'hE7,0); expect_out("rst9", 0,0,8'h00,0,0,0,0);
    step(0,0,8'h00,0); expect_out("rst10", 1,0,8'h00,0,0,0,0);
    step(0,0,8'h00,1); expect_out("rst11", 0,1,8'hE7,0,0,0,1);
    step(0,0,8'h00,0); expect_out("rst12", 0,0,8'h00,0,0,0,0);

    // grant withheld: 15 request cycles, timeout pulse, RELEASE + IDLE, retry
    step(0,1,8'h5A,0); expect_out("tmo_push", 0,0,8'h00,0,0,0,0);
    req_hi = 0;
    tmo_n  = 0;
    for (int i = 0; i < 15; i++) begin
      step(0,0,8'h00,0);
      if (req) req_hi++;
      if (timeout) tmo_n++;
    end
    chk("tmo_req_cycles", req_hi, 15);
    chk("tmo_early_pulse", tmo_n, 0);
    step(0,0,8'h00,0); expect_out("tmo_fire", 0,0,8'h00,0,0,1,0);
    step(0,0,8'h00,0); expect_out("tmo_idle", 0,0,8'h00,0,0,0,0);
    step(0,0,8'h00,0); expect_out("tmo_rereq", 1,0,8'h00,0,0,0,0);
    step(0,0,8'h00,1); expect_out("tmo_deliver", 0,1,8'h5A,0,0,0,1);
    step(0,0,8'h00,0); expect_out("tmo_done", 0,0,8'h00,0,0,0,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
